// File: rtl/MIDI.sv
// Shared MIDI channel-voice message types and byte-class constants for the
// parser and its downstream consumers.
package MIDI;

  typedef enum logic [3:0] {
    NOTE_OFF         = 4'h8,
    NOTE_ON          = 4'h9,
    POLY_PRESSURE    = 4'hA,
    CONTROL_CHANGE   = 4'hB,
    PROGRAM_CHANGE   = 4'hC,
    CHANNEL_PRESSURE = 4'hD,
    PITCH_BEND       = 4'hE
  } message_type_t;

  typedef struct packed {
    message_type_t message_type;
    logic [3:0]    channel;
    logic [6:0]    data_byte1;
    logic [6:0]    data_byte2;
  } message_t;

  localparam logic [7:0] SYSEX_START  = 8'hF0;
  localparam logic [7:0] SYSEX_END    = 8'hF7;
  localparam logic [7:0] REALTIME_MIN = 8'hF8;

  // Program change and channel pressure carry one data byte; all others two.
  function automatic logic [1:0] data_bytes_for_type(input message_type_t message_type);
    case (message_type)
      PROGRAM_CHANGE, CHANNEL_PRESSURE: return 2'd1;
      default:                          return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/midi_message_parser.sv
// Byte-stream MIDI parser with running status; drops sysex/common/real-time.
// Define MIDI_CHANNEL_FILTER_EN to deliver only messages on LISTEN_CHANNEL.
module midi_message_parser
  import MIDI::*;
#(
  parameter logic [3:0] LISTEN_CHANNEL = 4'd0
) (
  input  logic          clock_50_000_000,
  input  logic          reset_l,
  input  logic [7:0]    rx_byte,
  input  logic          rx_valid,
  output message_t      message,
  output logic          message_valid,
  output logic          parse_error
);

  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, DISCARD} state_t;

  state_t        state;
  message_type_t running_type;
  logic [3:0]    running_channel;
  logic [6:0]    data_byte1;
  logic          deliver;

`ifdef MIDI_CHANNEL_FILTER_EN
  assign deliver = (running_channel == LISTEN_CHANNEL);
`else
  logic unused_listen_channel;
  assign unused_listen_channel = ^LISTEN_CHANNEL;
  assign deliver = 1'b1;
`endif

  wire is_channel_status = rx_byte[7] && (rx_byte < SYSEX_START);

  always_ff @(posedge clock_50_000_000) begin
    // NOTE: every register here is state, so all use non-blocking assignment.
    if (!reset_l) begin
      state           <= IDLE;
      running_type    <= message_type_t'(4'h0);
      running_channel <= 4'h0;
      data_byte1      <= 7'h00;
      message         <= '0;
      message_valid   <= 1'b0;
      parse_error     <= 1'b0;
    end else begin
      message_valid <= 1'b0;
      parse_error   <= 1'b0;
      // Real-time bytes fall through untouched so they can interleave anywhere.
      if (rx_valid && rx_byte < REALTIME_MIN) begin
        if (is_channel_status) begin
          running_type    <= message_type_t'(rx_byte[7:4]);
          running_channel <= rx_byte[3:0];
          state           <= WAIT_D1;
        end else if (rx_byte == SYSEX_END) begin
          running_type    <= message_type_t'(4'h0);
          running_channel <= 4'h0;
          state           <= IDLE;
        end else if (rx_byte[7]) begin
          running_type    <= message_type_t'(4'h0);
          running_channel <= 4'h0;
          state           <= DISCARD;
        end else begin
          case (state)
            IDLE:    parse_error <= 1'b1;
            DISCARD: ;
            WAIT_D1: begin
              if (data_bytes_for_type(running_type) == 2'd1) begin
                if (deliver) begin
                  message       <= '{message_type: running_type, channel: running_channel,
                                     data_byte1: rx_byte[6:0], data_byte2: 7'h00};
                  message_valid <= 1'b1;
                end
              end else begin
                data_byte1 <= rx_byte[6:0];
                state      <= WAIT_D2;
              end
            end
            WAIT_D2: begin
              if (deliver) begin
                message       <= '{message_type: running_type, channel: running_channel,
                                   data_byte1: data_byte1, data_byte2: rx_byte[6:0]};
                message_valid <= 1'b1;
              end
              // Running status: further data bytes open a new message of this type.
              state <= WAIT_D1;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule
